hazard_ctrl: RTL

//  Pipeline hazard/stall controller for the 5-stage MIPS datapath; drives pc.hazard and
//  pc.BranchBubble. Detects load-use and branch-operand hazards (combinational stall) and

---
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand stall detection and post-branch fetch bubble sequencer.
// Optional HAZARD_STATS_EN adds StallCnt/BubbleCnt cycle counters.
module hazard_ctrl #(
  parameter int unsigned BRANCH_BUBBLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic        ID_Branch,
  input  logic        ID_Jump,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_Dst,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_Dst,
  output logic        hazard,
  output logic        BranchBubble,
  output logic        IDEX_Flush,
`ifdef HAZARD_STATS_EN
  output logic        IFID_Flush,
  output logic [31:0] StallCnt,
  output logic [31:0] BubbleCnt
`else
  output logic        IFID_Flush
`endif
);

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;

  logic w_rs_ex;
  logic w_rt_ex;
  logic w_rs_mem;
  logic w_rt_mem;
  logic w_ctl;
  logic w_load_use;
  logic w_br_dep;
  logic w_hazard;

  // $zero is never a real producer, so it can never match
  assign w_rs_ex  = ID_UseRs && (ID_Rs == EX_Dst) && (EX_Dst != 5'd0);
  assign w_rt_ex  = ID_UseRt && (ID_Rt == EX_Dst) && (EX_Dst != 5'd0);
  assign w_rs_mem = ID_UseRs && (ID_Rs == MEM_Dst) && (MEM_Dst != 5'd0);
  assign w_rt_mem = ID_UseRt && (ID_Rt == MEM_Dst) && (MEM_Dst != 5'd0);

  assign w_ctl      = ID_Branch || ID_Jump;
  assign w_load_use = EX_MemRead && (w_rs_ex || w_rt_ex);
  assign w_br_dep   = w_ctl &&
                      ((EX_RegWrite && (w_rs_ex || w_rt_ex)) ||
                       (MEM_MemRead && (w_rs_mem || w_rt_mem)));

  assign w_hazard = (w_load_use || w_br_dep) &&
                    (r_state == RUN) && !Reset;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      RUN: begin
        if (w_ctl && !w_hazard) begin
          w_state_nxt = BUBBLE;
          w_cnt_nxt   = 3'(BRANCH_BUBBLES);
        end
      end
      BUBBLE: begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign hazard       = w_hazard;
  assign IDEX_Flush   = w_hazard;
  assign BranchBubble = (r_state == BUBBLE);
  assign IFID_Flush   = (r_state == BUBBLE);

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else begin
      if (w_hazard && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (BranchBubble && (r_bubble_cnt != 32'hFFFF_FFFF))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign StallCnt  = r_stall_cnt;
  assign BubbleCnt = r_bubble_cnt;
`endif

endmodule
